// File: rtl/imem_loader.sv
// imem_loader: program loader for instruction memory.
// Receives a byte stream (word count, then big-endian 32-bit words) over a
// valid/ready handshake and writes each word into instruction memory through
// a single-cycle write port at consecutive word-aligned byte addresses.
// Optional feature macro: IMEM_LOADER_CHECKSUM_EN adds a trailing XOR
// checksum byte and the Error flag; without it Error is tied low.
//
// Handshake: a byte moves on every rising edge where ByteValid && ByteReady.
// ByteReady is a register that depends on the FSM state only, never on
// ByteValid; a source offered while ByteReady=0 must hold its byte.
module imem_loader #(
  parameter int ADDR_W = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              Start,
  input  logic [7:0]        ByteIn,
  input  logic              ByteValid,
  output logic              ByteReady,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [31:0]       WrData,
  output logic              Busy,
  output logic              Done,
  output logic              Error,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LEN   = 3'd1,
    S_DATA  = 3'd2,
    S_WRITE = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    S_CHK   = 3'd4,
`endif
    S_DONE  = 3'd5
  } state_t;

  state_t     state;
  logic [8:0] words_left;  // 1..256 words still to be written
  logic [1:0] byte_idx;    // position of the next byte inside the word
  logic       xfer;

  assign xfer      = ByteValid && ByteReady;
  assign dbg_state = state;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] xor_acc;
  logic       error_q;
  assign Error = error_q;

  // Checksum accumulator and mismatch flag; cleared on each new load.
  always_ff @(posedge clk) begin
    if (reset) begin
      xor_acc <= 8'd0;
      error_q <= 1'b0;
    end else begin
      if ((state == S_IDLE || state == S_DONE) && Start) begin
        xor_acc <= 8'd0;
        error_q <= 1'b0;
      end else if (state == S_DATA && xfer) begin
        xor_acc <= xor_acc ^ ByteIn;
      end else if (state == S_CHK && xfer) begin
        error_q <= (ByteIn != xor_acc);
      end
    end
  end
`else
  assign Error = 1'b0;
`endif

  // Main loader FSM; all outputs are registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      ByteReady  <= 1'b0;
      WrEn       <= 1'b0;
      WrAddr     <= BASE_ADDR;
      WrData     <= 32'd0;
      Busy       <= 1'b0;
      Done       <= 1'b0;
      words_left <= 9'd0;
      byte_idx   <= 2'd0;
    end else begin
      WrEn <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (Start) begin
            state     <= S_LEN;
            ByteReady <= 1'b1;
            Busy      <= 1'b1;
            Done      <= 1'b0;
          end
        end
        S_LEN: begin
          if (xfer) begin
            state      <= S_DATA;
            // A count byte of zero stands for a full 256-word program.
            words_left <= (ByteIn == 8'd0) ? 9'd256 : {1'b0, ByteIn};
            byte_idx   <= 2'd0;
            WrAddr     <= BASE_ADDR;
          end
        end
        S_DATA: begin
          if (xfer) begin
            // First byte of a word is its most significant byte.
            case (byte_idx)
              2'd0:    WrData[31:24] <= ByteIn;
              2'd1:    WrData[23:16] <= ByteIn;
              2'd2:    WrData[15:8]  <= ByteIn;
              default: WrData[7:0]   <= ByteIn;
            endcase
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state     <= S_WRITE;
              ByteReady <= 1'b0;
              WrEn      <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          // Address wraps naturally at the top of the ADDR_W space.
          WrAddr     <= WrAddr + ADDR_W'(4);
          words_left <= words_left - 9'd1;
          if (words_left == 9'd1) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state     <= S_CHK;
            ByteReady <= 1'b1;
`else
            state     <= S_DONE;
            ByteReady <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b1;
`endif
          end else begin
            state     <= S_DATA;
            ByteReady <= 1'b1;
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHK: begin
          if (xfer) begin
            state     <= S_DONE;
            ByteReady <= 1'b0;
            Busy      <= 1'b0;
            Done      <= 1'b1;
          end
        end
`endif
        default: begin
          state     <= S_IDLE;
          ByteReady <= 1'b0;
          Busy      <= 1'b0;
          Done      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: two instances (base 0 and base 4) share one stimulus.
// Expected writes are derived from the word stream sent; the compare process
// checks every write strobe against that queue.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        Start;
  logic [7:0]  ByteIn;
  logic        ByteValid;

  logic        ready0, wren0, busy0, done0, err0;
  logic [9:0]  addr0;
  logic [31:0] data0;
  logic [2:0]  st0;
  logic        ready4, wren4, busy4, done4, err4;
  logic [9:0]  addr4;
  logic [31:0] data4;
  logic [2:0]  st4;

  int checks = 0;
  int errors = 0;
  int hs_count = 0;
  int wr_count = 0;
  logic [9:0] last_addr4;
  logic [7:0] cks;
  logic [41:0] exp_q[$];  // {base-0 address, data}

  imem_loader #(.ADDR_W(10), .BASE_ADDR(10'h000)) dut0 (
    .clk(clk), .reset(reset), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
    .ByteReady(ready0), .WrEn(wren0), .WrAddr(addr0), .WrData(data0),
    .Busy(busy0), .Done(done0), .Error(err0), .dbg_state(st0));

  imem_loader #(.ADDR_W(10), .BASE_ADDR(10'h004)) dut4 (
    .clk(clk), .reset(reset), .Start(Start), .ByteIn(ByteIn), .ByteValid(ByteValid),
    .ByteReady(ready4), .WrEn(wren4), .WrAddr(addr4), .WrData(data4),
    .Busy(busy4), .Done(done4), .Error(err4), .dbg_state(st4));

  // clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // handshake monitor: a byte moves at the next rising edge
  always @(negedge clk) begin
    if (!reset && ByteValid && ready0) hs_count++;
  end

  // compare process: every write strobe must match the head of the model queue
  always @(negedge clk) begin
    logic [41:0] e;
    logic [9:0]  a4;
    if (wren0 || wren4) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h required=no write", addr0, data0);
      end else begin
        e  = exp_q.pop_front();
        a4 = e[41:32] + 10'd4;
        check("wr_addr0", addr0, e[41:32]);
        check("wr_data0", data0, e[31:0]);
        check("wr_en4",   wren4, 1);
        check("wr_en0",   wren0, 1);
        check("wr_addr4", addr4, a4);
        check("wr_data4", data4, e[31:0]);
        check("ready_in_write", ready0, 0);
      end
      wr_count++;
      last_addr4 = addr4;
    end
  end

  // model: word idx lands at base + 4*idx (10-bit wrap)
  task automatic push_exp(input int idx, input logic [31:0] w);
    logic [9:0] a;
    a = 10'(idx * 4);
    exp_q.push_back({a, w});
  endtask

  // driver tasks; all called at posedge+#1
  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 0;
    ByteIn = b;
    ByteValid = 1'b1;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (ready0) ok = 1;
    end
    @(posedge clk);
    #1;
    ByteValid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL byte_timeout actual=ready low required=ready high");
    end
  endtask

  task automatic pulse_start();
    Start = 1'b1;
    @(posedge clk);
    #1;
    Start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int idx, input bit gap);
    logic [7:0] b;
    push_exp(idx, w);
    for (int k = 0; k < 4; k++) begin
      b = w[31-8*k -: 8];
      cks = cks ^ b;
      send_byte(b);
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_done(input logic exp_err);
    bit ok;
    ok = 0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(negedge clk);
      if (done0) ok = 1;
    end
    check("done", done0, 1);
    check("busy_at_done", busy0, 0);
    check("ready_at_done", ready0, 0);
    check("error_at_done", err0, exp_err);
    @(posedge clk);
    #1;
  endtask

  task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(cks);
`endif
    wait_done(1'b0);
  endtask

  task automatic begin_load(input logic [7:0] n);
    pulse_start();
    @(negedge clk);
    check("busy_after_start", busy0, 1);
    check("done_cleared", done0, 0);
    @(posedge clk);
    #1;
    cks = 8'd0;
    send_byte(n);
  endtask

  task automatic check_reset_values();
    @(negedge clk);
    check("rst_ready", ready0, 0);
    check("rst_wren", wren0, 0);
    check("rst_addr0", addr0, 10'h000);
    check("rst_addr4", addr4, 10'h004);
    check("rst_data", data0, 0);
    check("rst_busy", busy0, 0);
    check("rst_done", done0, 0);
    check("rst_error", err0, 0);
    check("rst_state_idle", st0, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs0;
    reset = 1'b1;
    Start = 1'b0;
    ByteIn = 8'd0;
    ByteValid = 1'b0;
    cks = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_values();

    // reset mid-word, with Start asserted in the reset cycle too
    begin_load(8'd5);
    send_byte(8'hAA);
    send_byte(8'hBB);
    reset = 1'b1;
    Start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    Start = 1'b0;
    check_reset_values();

    // single word, back-to-back bytes
    begin_load(8'd1);
    send_word(32'h20080005, 0, 1'b0);
    @(negedge clk);
    check("single_wren", wren0, 1);
    check("single_addr", addr0, 10'h000);
    check("single_data", data0, 32'h20080005);
    check("single_addr4", addr4, 10'h004);
    check("single_not_done_yet", done0, 0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    @(negedge clk);
    check("single_done_2cyc", done0, 1);
    check("single_busy_low", busy0, 0);
    @(posedge clk);
    #1;
`else
    @(posedge clk);
    #1;
`endif
    finish_load();

    // three words, ByteValid toggling every other cycle
    hs0 = hs_count;
    begin_load(8'd3);
    send_word(32'hDEADBEEF, 0, 1'b1);
    send_word(32'h00112233, 1, 1'b1);
    send_word(32'hA5A55A5A, 2, 1'b1);
    finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("three_word_bytes", hs_count - hs0, 14);
`else
    check("three_word_bytes", hs_count - hs0, 13);
`endif

    // Start during DATA is ignored
    hs0 = hs_count;
    begin_load(8'd2);
    push_exp(0, 32'h11223344);
    cks = 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44;
    send_byte(8'h11);
    send_byte(8'h22);
    pulse_start();
    send_byte(8'h33);
    send_byte(8'h44);
    send_word(32'h55667788, 1, 1'b0);
    finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
    check("start_ignored_bytes", hs_count - hs0, 10);
`else
    check("start_ignored_bytes", hs_count - hs0, 9);
`endif

    // LEN=0 means 256 words; base-4 instance wraps to 0 on the last write
    wr_count = 0;
    begin_load(8'd0);
    for (int i = 0; i < 256; i++) begin
      send_word({8'(i), 8'(~i), 8'(i * 3), 8'h5C}, i, 1'b0);
    end
    finish_load();
    check("len0_writes", wr_count, 256);
    check("len0_last_addr4", last_addr4, 10'h000);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // checksum good then bad; the word is written in both cases
    wr_count = 0;
    begin_load(8'd1);
    send_word(32'h01020304, 0, 1'b0);
    send_byte(8'h04);
    wait_done(1'b0);
    begin_load(8'd1);
    send_word(32'h01020304, 0, 1'b0);
    send_byte(8'h05);
    wait_done(1'b1);
    check("chk_writes", wr_count, 2);
    begin_load(8'd1);
    check("error_cleared_by_start", err0, 0);
    send_word(32'h01020304, 0, 1'b0);
    send_byte(8'h04);
    wait_done(1'b0);
`endif

    repeat (3) @(posedge clk);
    check("exp_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
